// File: rtl/sp_ram_pkg.sv
// Shared encodings for the single-port RAM controller.
package sp_ram_pkg;

    // Read-during-write policy selectors for the WR_MODE parameter.
    localparam int WR_READ_FIRST  = 0;
    localparam int WR_WRITE_FIRST = 1;
    localparam int WR_NO_CHANGE   = 2;

    // Controller states: zero-filling the array, or serving accesses.
    typedef enum logic [0:0] {
        StClear = 1'b0,
        StIdle  = 1'b1
    } state_e;

endpackage

// File: rtl/sp_ram_array.sv
// Bare single-port storage array, 2**AW words of W bits, with a registered
// read port that applies the read-during-write policy selected by WR_MODE.
module sp_ram_array
    import sp_ram_pkg::*;
#(
    parameter int unsigned W       = 4,
    parameter int unsigned AW      = 5,
    parameter int          WR_MODE = WR_NO_CHANGE
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Storage write; contents are never reset, the controller zero-fills them.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register: updated only on accepted requests, per the write policy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_req) begin
            if (!i_we) begin
                r_rdata <= r_mem[i_addr];
            end else if (WR_MODE == WR_READ_FIRST) begin
                r_rdata <= r_mem[i_addr];
            end else if (WR_MODE == WR_WRITE_FIRST) begin
                r_rdata <= i_wdata;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sp_ram_ctrl.sv
// Parametrised single-port synchronous RAM with request/valid handshake and a
// hardware zero-fill sequencer that runs after reset and on a clr pulse.
// Optional build macro SP_RAM_PARITY_EN adds one even-parity bit per word and
// a perr output that pulses with dvalid when a read word fails its parity.
module sp_ram_ctrl
    import sp_ram_pkg::*;
#(
    parameter int unsigned DW      = 4,
    parameter int unsigned AW      = 5,
    parameter int          WR_MODE = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          w,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          clr,
    output logic          rdy,
    output logic [DW-1:0] dout,
    output logic          dvalid
`ifdef SP_RAM_PARITY_EN
    ,
    output logic          perr
`endif
);

`ifdef SP_RAM_PARITY_EN
    localparam int unsigned PW = 1;
`else
    localparam int unsigned PW = 0;
`endif
    localparam int unsigned W = DW + PW;

    state_e        r_state;
    state_e        w_state_next;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_next;
    logic          r_dvalid;
    logic          w_dvalid_next;
    logic          w_mem_we;
    logic          w_req;
    logic [AW-1:0] w_addr;
    logic [W-1:0]  w_wdata;
    logic [W-1:0]  w_word;
    logic [W-1:0]  w_rdata;

`ifdef SP_RAM_PARITY_EN
    assign w_word = {^din, din};
`else
    assign w_word = din;
`endif

    // State, clear counter and valid strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StClear;
            r_cnt    <= '0;
            r_dvalid <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_dvalid <= w_dvalid_next;
        end
    end

    // Next-state, clear sweep and access arbitration (clr beats en).
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_mem_we      = 1'b0;
        w_req         = 1'b0;
        w_addr        = addr;
        w_wdata       = w_word;
        w_dvalid_next = 1'b0;
        unique case (r_state)
            StClear: begin
                w_mem_we   = 1'b1;
                w_addr     = r_cnt;
                w_wdata    = '0;
                // Natural wrap returns the counter to 0 as the sweep ends.
                w_cnt_next = r_cnt + 1'b1;
                if (&r_cnt) begin
                    w_state_next = StIdle;
                end
            end
            StIdle: begin
                if (clr) begin
                    w_state_next = StClear;
                end else if (en) begin
                    w_req         = 1'b1;
                    w_mem_we      = w;
                    w_dvalid_next = !w || (WR_MODE != WR_NO_CHANGE);
                end
            end
            default: begin
                w_state_next = StClear;
            end
        endcase
    end

    sp_ram_array #(
        .W       (W),
        .AW      (AW),
        .WR_MODE (WR_MODE)
    ) u_array (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (w_mem_we),
        .i_req   (w_req),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign rdy    = (r_state == StIdle);
    assign dout   = w_rdata[DW-1:0];
    assign dvalid = r_dvalid;

`ifdef SP_RAM_PARITY_EN
    // Stored words carry even parity, so any odd word is corrupt.
    assign perr = r_dvalid & (^w_rdata);
`endif

endmodule
